// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter.
// Widths, result entry layout and the round-robin picker.
package mult_share_pkg;
  localparam int N_REQ      = 4;
  localparam int WA         = 6;
  localparam int WB         = 6;
  localparam int MUL_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int PROD_W     = WA + WB;
  localparam int IDW        = $clog2(N_REQ);
  localparam int PTRW       = $clog2(FIFO_DEPTH);
  localparam int CNTW       = PTRW + 1;

  typedef struct packed {
    logic [IDW-1:0]    id;
    logic [PROD_W-1:0] prod;
  } res_entry_t;

  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [IDW:0] rr_next(input logic [N_REQ-1:0] vld,
                                           input logic [IDW-1:0]   ptr);
    logic [IDW:0]   r;
    logic [IDW-1:0] idx;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (vld[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction
endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester, multiplier and result-stream signals of the shared multiplier.
// slave = arbiter side, master = surrounding logic / requesters.
interface mult_share_arbiter_if;
  import mult_share_pkg::*;

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*WA-1:0] req_a;
  logic [N_REQ*WB-1:0] req_b;
  logic [WA-1:0]       mul_a;
  logic [WB-1:0]       mul_b;
  logic                mul_en;
  logic [PROD_W-1:0]   mul_sum;
  logic                res_valid;
  logic                res_ready;
  logic [IDW-1:0]      res_id;
  logic [PROD_W-1:0]   res_prod;
  logic                busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_sum, res_ready,
    output req_ready, mul_a, mul_b, mul_en, res_valid, res_id, res_prod, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_sum, res_ready,
    input  req_ready, mul_a, mul_b, mul_en, res_valid, res_id, res_prod, busy
  );
endinterface

// File: rtl/mult_share_fifo.sv
// Synchronous result FIFO with occupancy count; head entry shown combinationally.
// Push into a full FIFO is excluded by the arbiter's credit check.
module mult_share_fifo
  import mult_share_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             push,
  input  res_entry_t       push_dat,
  input  logic             pop,
  output res_entry_t       head_dat,
  output logic [CNTW-1:0]  count
);
  res_entry_t      mem [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_pop;

  assign do_pop   = pop && (count != '0);
  assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
    !(push && !do_pop && count == CNTW'(FIFO_DEPTH)));
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 2-stage multiplier; results tagged by requester ID.
// Issue is credit-limited so the result FIFO can never overflow; req_ready ignores res_ready.
module mult_share_arbiter
  import mult_share_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  mult_share_arbiter_if.slave  bus
);
  localparam logic [CNTW:0] DEPTH_C = FIFO_DEPTH;

  logic [MUL_LAT-1:0] stg_vld;
  logic [IDW-1:0]     stg_id [MUL_LAT];
  logic [IDW-1:0]     rr_ptr;
  logic [CNTW-1:0]    fifo_count;
  logic [CNTW-1:0]    inflight_count;
  logic [CNTW:0]      occupancy;
  logic [IDW:0]       pick;
  logic [IDW-1:0]     win;
  logic               credit;
  logic               issue;
  logic               pop;
  res_entry_t         head;

  always_comb begin
    inflight_count = '0;
    for (int k = 0; k < MUL_LAT; k++) inflight_count = inflight_count + CNTW'(stg_vld[k]);
  end

  // Pops in the current cycle are not credited back until the next one.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign credit    = occupancy < DEPTH_C;
  assign pick      = rr_next(bus.req_valid, rr_ptr);
  assign win       = pick[IDW-1:0];
  assign issue     = !sys_rst && credit && pick[IDW];

  assign bus.req_ready = issue ? (N_REQ'(1) << win) : '0;
  assign bus.mul_a     = issue ? bus.req_a[win*WA +: WA] : '0;
  assign bus.mul_b     = issue ? bus.req_b[win*WB +: WB] : '0;
  assign bus.mul_en    = !sys_rst && (issue || (|stg_vld[MUL_LAT-2:0]));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stg_vld <= '0;
      stg_id  <= '{default: '0};
      rr_ptr  <= '0;
    end else begin
      stg_vld   <= {stg_vld[MUL_LAT-2:0], issue};
      stg_id[0] <= win;
      for (int k = 1; k < MUL_LAT; k++) stg_id[k] <= stg_id[k-1];
      if (issue) rr_ptr <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  assign bus.res_valid = !sys_rst && (fifo_count != '0);
  assign pop           = bus.res_valid && bus.res_ready;
  assign bus.res_id    = bus.res_valid ? head.id   : '0;
  assign bus.res_prod  = bus.res_valid ? head.prod : '0;
  assign bus.busy      = !sys_rst && ((inflight_count != '0) || (fifo_count != '0));

  mult_share_fifo u_fifo (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .push     (stg_vld[MUL_LAT-1]),
    .push_dat ('{id: stg_id[MUL_LAT-1], prod: bus.mul_sum}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: exact 2-stage multiplier model plus in-order result scoreboard.
module tb_mult_share_arbiter;
  import mult_share_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  mult_share_arbiter_if bus ();
  mult_share_arbiter dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

  int         n_chk   = 0;
  int         n_pass  = 0;
  int         exp_ptr = 0;
  string      cur     = "init";
  res_entry_t exp_q[$];

  // Exact multiplier: input register, then product register; en low clears both.
  logic [WA-1:0] m_ra;
  logic [WB-1:0] m_rb;
  always @(posedge sys_clk) begin
    if (!bus.mul_en) begin
      m_ra <= '0; m_rb <= '0; bus.mul_sum <= '0;
    end else begin
      m_ra <= bus.mul_a; m_rb <= bus.mul_b;
      bus.mul_sum <= PROD_W'(m_ra) * PROD_W'(m_rb);
    end
  end

  // Scoreboard: expectation pushed at each handshake, compared when a result is consumed.
  always @(negedge sys_clk) begin
    res_entry_t e;
    if (sys_rst) exp_q.delete();
    else begin
      if (bus.res_valid && bus.res_ready) begin
        n_chk++;
        if (exp_q.size() == 0)
          $display("FAIL %s sb_extra: got id=%0d prod=%0d, required no result", cur, bus.res_id, bus.res_prod);
        else begin
          e = exp_q.pop_front();
          if (bus.res_id !== e.id || bus.res_prod !== e.prod)
            $display("FAIL %s sb_result: got id=%0d prod=%0d, required id=%0d prod=%0d",
                     cur, bus.res_id, bus.res_prod, e.id, e.prod);
          else n_pass++;
        end
      end
      for (int i = 0; i < N_REQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i])
          exp_q.push_back('{id: IDW'(i),
                            prod: PROD_W'(bus.req_a[i*WA +: WA]) * PROD_W'(bus.req_b[i*WB +: WB])});
    end
  end

  task automatic nxt(); @(posedge sys_clk); #1; endtask
  task automatic mid(); @(negedge sys_clk); endtask

  task automatic drive_ops();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[i*WA +: WA] = WA'($urandom);
      bus.req_b[i*WB +: WB] = WB'($urandom);
    end
  endtask

  task automatic test_reset();
    cur = "reset";
    sys_rst = 1'b1; bus.req_valid = '1; bus.res_ready = 1'b1; drive_ops();
    nxt(); nxt(); mid();
    n_chk++;
    if ({bus.req_ready, bus.mul_en, bus.res_valid, bus.busy, bus.mul_a, bus.mul_b, bus.res_id, bus.res_prod} !== '0)
      $display("FAIL reset during: rdy=%b en=%b rv=%b busy=%b a=%0d b=%0d id=%0d prod=%0d, required all 0",
               bus.req_ready, bus.mul_en, bus.res_valid, bus.busy, bus.mul_a, bus.mul_b, bus.res_id, bus.res_prod);
    else n_pass++;
    nxt(); sys_rst = 1'b0; bus.req_valid = '0; mid();
    n_chk++;
    if ({bus.req_ready, bus.mul_en, bus.res_valid, bus.busy, bus.mul_a, bus.mul_b, bus.res_id, bus.res_prod} !== '0)
      $display("FAIL reset after: rdy=%b en=%b rv=%b busy=%b, required all 0",
               bus.req_ready, bus.mul_en, bus.res_valid, bus.busy);
    else n_pass++;
    exp_ptr = 0;
    nxt();
  endtask

  task automatic test_single();
    cur = "single";
    bus.req_a = '0; bus.req_b = '0;
    bus.req_a[0 +: WA] = WA'(5); bus.req_b[0 +: WB] = WB'(7);
    bus.req_valid = 4'b0001; bus.res_ready = 1'b1;
    mid();
    n_chk++;
    if ({bus.req_ready, bus.mul_en, bus.mul_a, bus.mul_b} !== {4'b0001, 1'b1, WA'(5), WB'(7)})
      $display("FAIL single issue: rdy=%b en=%b a=%0d b=%0d, required 0001 1 5 7",
               bus.req_ready, bus.mul_en, bus.mul_a, bus.mul_b);
    else n_pass++;
    nxt(); bus.req_valid = '0; mid();
    n_chk++;
    if ({bus.mul_en, bus.res_valid, bus.busy} !== 3'b101)
      $display("FAIL single cyc1: en/rv/busy=%b, required 101", {bus.mul_en, bus.res_valid, bus.busy});
    else n_pass++;
    nxt(); mid();
    n_chk++;
    if ({bus.mul_en, bus.res_valid} !== 2'b00)
      $display("FAIL single cyc2: en/rv=%b, required 00", {bus.mul_en, bus.res_valid});
    else n_pass++;
    // Product becomes visible two edges after the handshake edge.
    nxt(); mid();
    n_chk++;
    if ({bus.res_valid, bus.res_id, bus.res_prod} !== {1'b1, IDW'(0), PROD_W'(35)})
      $display("FAIL single result: rv=%b id=%0d prod=%0d, required 1 0 35", bus.res_valid, bus.res_id, bus.res_prod);
    else n_pass++;
    nxt(); mid();
    n_chk++;
    if ({bus.res_valid, bus.busy} !== 2'b00 || exp_q.size() != 0)
      $display("FAIL single drained: rv=%b busy=%b pending=%0d, required 0 0 0", bus.res_valid, bus.busy, exp_q.size());
    else n_pass++;
    exp_ptr = 1;
    nxt();
  endtask

  task automatic test_stream();
    logic [N_REQ-1:0] exp_rdy;
    cur = "stream";
    bus.res_ready = 1'b1; bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      drive_ops(); mid();
      exp_rdy = N_REQ'(1) << exp_ptr;
      n_chk++;
      if (bus.req_ready !== exp_rdy)
        $display("FAIL stream grant%0d: got %b, required %b", k, bus.req_ready, exp_rdy);
      else n_pass++;
      exp_ptr = (exp_ptr + 1) % N_REQ;
      nxt();
    end
    bus.req_valid = '0;
    repeat (5) nxt();
    mid();
    n_chk++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL stream drained: busy=%b pending=%0d, required 0 0", bus.busy, exp_q.size());
    else n_pass++;
    nxt();
  endtask

  task automatic test_backpressure();
    logic [N_REQ-1:0] exp_rdy;
    cur = "backpressure";
    bus.res_ready = 1'b0; bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      drive_ops(); mid();
      exp_rdy = (k < FIFO_DEPTH) ? N_REQ'(1) << exp_ptr : '0;
      n_chk++;
      if (bus.req_ready !== exp_rdy)
        $display("FAIL backpressure issue%0d: got %b, required %b", k, bus.req_ready, exp_rdy);
      else n_pass++;
      if (k < FIFO_DEPTH) exp_ptr = (exp_ptr + 1) % N_REQ;
      nxt();
    end
    bus.res_ready = 1'b1; mid();
    n_chk++;
    if ({bus.req_ready, bus.res_valid, bus.busy} !== {4'b0000, 1'b1, 1'b1})
      $display("FAIL backpressure first_pop: rdy=%b rv=%b busy=%b, required 0000 1 1",
               bus.req_ready, bus.res_valid, bus.busy);
    else n_pass++;
    nxt(); mid();
    exp_rdy = N_REQ'(1) << exp_ptr;
    n_chk++;
    if (bus.req_ready !== exp_rdy)
      $display("FAIL backpressure resume: got %b, required %b", bus.req_ready, exp_rdy);
    else n_pass++;
    exp_ptr = (exp_ptr + 1) % N_REQ;
    nxt(); bus.req_valid = '0;
    repeat (8) nxt();
    mid();
    n_chk++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL backpressure drained: busy=%b pending=%0d, required 0 0", bus.busy, exp_q.size());
    else n_pass++;
    nxt();
  endtask

  task automatic test_fairness();
    logic [N_REQ-1:0] vl [4];
    logic [N_REQ-1:0] ex [4];
    vl = '{4'b0100, 4'b1100, 4'b1100, 4'b1100};
    ex = '{4'b0100, 4'b1000, 4'b0100, 4'b1000};
    cur = "fairness";
    bus.res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = vl[k]; drive_ops(); mid();
      n_chk++;
      if (bus.req_ready !== ex[k])
        $display("FAIL fairness grant%0d: got %b, required %b", k, bus.req_ready, ex[k]);
      else n_pass++;
      nxt();
    end
    bus.req_valid = '0; exp_ptr = 0;
    repeat (4) nxt();
    mid();
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL fairness drained: pending=%0d, required 0", exp_q.size());
    else n_pass++;
    nxt();
  endtask

  task automatic test_reset_mid();
    logic stale;
    int   w;
    cur = "reset_mid";
    bus.res_ready = 1'b0; bus.req_valid = '1;
    repeat (3) begin drive_ops(); nxt(); end
    bus.req_valid = '0; sys_rst = 1'b1; mid();
    n_chk++;
    if (dut.u_fifo.count !== CNTW'(1) || dut.stg_vld !== 2'b11 ||
        {bus.req_ready, bus.mul_en, bus.res_valid, bus.busy} !== '0)
      $display("FAIL reset_mid pre: count=%0d stg=%b rdy=%b en=%b rv=%b busy=%b, required 1 11 0 0 0 0",
               dut.u_fifo.count, dut.stg_vld, bus.req_ready, bus.mul_en, bus.res_valid, bus.busy);
    else n_pass++;
    nxt(); sys_rst = 1'b0; bus.res_ready = 1'b1; mid();
    n_chk++;
    if ({bus.req_ready, bus.mul_en, bus.res_valid, bus.busy, bus.res_id, bus.res_prod} !== '0)
      $display("FAIL reset_mid post: rdy=%b en=%b rv=%b busy=%b id=%0d prod=%0d, required all 0",
               bus.req_ready, bus.mul_en, bus.res_valid, bus.busy, bus.res_id, bus.res_prod);
    else n_pass++;
    stale = 1'b0;
    repeat (5) begin nxt(); mid(); if (bus.res_valid !== 1'b0) stale = 1'b1; end
    n_chk++;
    if (stale !== 1'b0) $display("FAIL reset_mid stale: res_valid seen=%b, required 0", stale);
    else n_pass++;
    nxt();
    exp_ptr = 0;
    bus.req_a[0 +: WA] = WA'(63); bus.req_b[0 +: WB] = WB'(63); bus.req_valid = 4'b0001;
    mid();
    n_chk++;
    if (bus.req_ready !== 4'b0001) $display("FAIL reset_mid grant: got %b, required 0001", bus.req_ready);
    else n_pass++;
    nxt(); bus.req_valid = '0;
    for (w = 0; w < 10; w++) begin
      mid();
      if (bus.res_valid === 1'b1) break;
      nxt();
    end
    n_chk++;
    if (w != MUL_LAT || {bus.res_valid, bus.res_id, bus.res_prod} !== {1'b1, IDW'(0), PROD_W'(3969)})
      $display("FAIL reset_mid 63x63: wait=%0d rv=%b id=%0d prod=%0d, required %0d 1 0 3969",
               w, bus.res_valid, bus.res_id, bus.res_prod, MUL_LAT);
    else n_pass++;
    exp_ptr = 1;
    nxt();
  endtask

  task automatic test_wrap();
    cur = "wrap";
    bus.res_ready = 1'b0;
    bus.req_valid = '1; drive_ops(); nxt(); drive_ops(); nxt();
    bus.req_valid = '0; nxt(); nxt();
    bus.req_valid = '1; drive_ops(); nxt(); drive_ops(); nxt();
    bus.res_ready = 1'b1; drive_ops(); mid();
    n_chk++;
    if (dut.u_fifo.count !== CNTW'(2) || bus.req_ready !== '0)
      $display("FAIL wrap pre: count=%0d rdy=%b, required 2 0000", dut.u_fifo.count, bus.req_ready);
    else n_pass++;
    nxt(); mid();
    n_chk++;
    if (dut.u_fifo.count !== CNTW'(2))
      $display("FAIL wrap push_pop: count=%0d, required 2", dut.u_fifo.count);
    else n_pass++;
    nxt();
    repeat (8) begin drive_ops(); nxt(); end
    bus.req_valid = '0;
    repeat (8) nxt();
    mid();
    n_chk++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL wrap drained: busy=%b pending=%0d, required 0 0", bus.busy, exp_q.size());
    else n_pass++;
    nxt();
  endtask

  initial begin
    sys_rst = 1'b1; bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached in %s", cur);
    $fatal(1);
  end
endmodule
